// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: per-frame latched prescale, data length, parity and stop bits,
// 3-sample majority voting, and a single-entry output register with overrun detection.
module uart_rx_cfg #(
  parameter int MAX_WIDTH  = 9,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic [3:0]            DATA_LEN,
  input  logic                  PARITY_ENABLE,
  input  logic                  PARITY_TYPE,
  input  logic                  STOP_BITS,
  input  logic                  DATA_READY,
  output logic [MAX_WIDTH-1:0]  P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  FRAME_ERR,
  output logic                  OVERRUN,
  output logic                  BUSY,
  output logic [2:0]            fsm_state
);

  // Output handshake: P_DATA is consumed on any cycle where DATA_VALID and DATA_READY are both high.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

  localparam logic [PRESCALE_W-1:0] P_MIN   = PRESCALE_W'(6);
  localparam logic [PRESCALE_W-1:0] ONE     = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO     = PRESCALE_W'(2);
  localparam logic [3:0]            LEN_MAX = 4'(MAX_WIDTH);

  state_t                  state, state_next;
  logic                    rx_s1, rx_s2, line;
  logic [PRESCALE_W-1:0]   p_lat, cnt, half;
  logic [3:0]              len_lat, bit_idx;
  logic                    pe_lat, pt_lat, sb_lat;
  logic [2:0]              samp;
  logic [MAX_WIDTH-1:0]    shreg;
  logic                    par_bit, stop_bad;
  logic                    bit_end, resolve, maj, par_bad, good, load;

  assign line    = rx_s2;
  assign half    = p_lat >> 1;
  assign bit_end = (cnt == p_lat - ONE);
  assign resolve = (cnt == half + TWO);
  assign maj     = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  // shreg is cleared at frame start, so reducing all of it equals reducing the received bits.
  assign par_bad = pe_lat && (par_bit != ((^shreg) ^ pt_lat));
  assign good    = (state == DONE) && !par_bad && !stop_bad;
  assign load    = good && (!DATA_VALID || DATA_READY);

  assign PAR_ERR   = (state == DONE) && par_bad;
  assign FRAME_ERR = (state == DONE) && stop_bad;
  assign OVERRUN   = good && DATA_VALID && !DATA_READY;
  assign BUSY      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!line) state_next = START;
      START: begin
        if (resolve && maj) state_next = IDLE;
        else if (bit_end)   state_next = DATA;
      end
      DATA:   if (bit_end && (bit_idx == len_lat - 4'd1))
                state_next = pe_lat ? PARITY : STOP1;
      PARITY: if (bit_end) state_next = STOP1;
      STOP1: begin
        if (sb_lat) begin
          if (bit_end) state_next = STOP2;
        end else if (resolve) begin
          state_next = DONE;
        end
      end
      STOP2:  if (resolve) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      cnt        <= '0;
      p_lat      <= '0;
      len_lat    <= '0;
      pe_lat     <= 1'b0;
      pt_lat     <= 1'b0;
      sb_lat     <= 1'b0;
      bit_idx    <= '0;
      samp       <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_bad   <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      rx_s1 <= RX_IN;
      rx_s2 <= rx_s1;

      // Cycle 0 of the start bit is spent in IDLE, so the first START cycle is count 1.
      if (state_next == IDLE || state_next == DONE) cnt <= '0;
      else if (state == IDLE)                        cnt <= ONE;
      else if (bit_end)                              cnt <= '0;
      else                                           cnt <= cnt + ONE;

      if (state == IDLE && !line) begin
        p_lat    <= (PRESCALE < P_MIN) ? P_MIN : PRESCALE;
        len_lat  <= (DATA_LEN < 4'd5 || DATA_LEN > LEN_MAX) ? LEN_MAX : DATA_LEN;
        pe_lat   <= PARITY_ENABLE;
        pt_lat   <= PARITY_TYPE;
        sb_lat   <= STOP_BITS;
        bit_idx  <= '0;
        shreg    <= '0;
        par_bit  <= 1'b0;
        stop_bad <= 1'b0;
      end

      if (state != IDLE && (cnt == half - ONE || cnt == half || cnt == half + ONE))
        samp <= {samp[1:0], line};

      if (resolve) begin
        case (state)
          DATA:          shreg[bit_idx] <= maj;
          PARITY:        par_bit <= maj;
          STOP1, STOP2:  if (!maj) stop_bad <= 1'b1;
          default: ;
        endcase
      end

      if (state == DATA && bit_end) bit_idx <= bit_idx + 4'd1;

      if (load) begin
        P_DATA     <= shreg;
        DATA_VALID <= 1'b1;
      end else if (DATA_VALID && DATA_READY) begin
        DATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 9, the widest data field supported (legal 5..9).
REQ-002 SHALL have parameter PRESCALE_W, default 6, the width of the PRESCALE input.
REQ-003 CLK  input  1  single clock; all logic on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 RX_IN  input  1  serial line, idle high, LSB first.
REQ-006 PRESCALE  input  PRESCALE_W  CLK cycles per bit.
REQ-007 DATA_LEN  input  4  data bits per frame (5..MAX_WIDTH).
REQ-008 PARITY_ENABLE  input  1  one parity bit follows the data.
REQ-009 PARITY_TYPE  input  1  0 = even, 1 = odd.
REQ-010 STOP_BITS  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 DATA_READY  input  1  consumer accepts P_DATA when high with DATA_VALID.
REQ-012 P_DATA  output  MAX_WIDTH  received word, right-aligned, unused MSBs zero.
REQ-013 DATA_VALID  output  1  P_DATA holds an unconsumed good frame.
REQ-014 PAR_ERR  output  1  one-cycle pulse on a parity mismatch.
REQ-015 FRAME_ERR  output  1  one-cycle pulse when any stop bit is sampled 0.
REQ-016 OVERRUN  output  1  one-cycle pulse when a good frame is dropped.
REQ-017 BUSY  output  1  FSM not in IDLE.

Function
REQ-018 RX_IN SHALL pass through a 2-flop synchronizer whose flops reset to 1; all references to the line below mean the synchronized value.
REQ-019 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP1, STOP2 and DONE.
REQ-020 On entry to START, PRESCALE, DATA_LEN, PARITY_ENABLE, PARITY_TYPE and STOP_BITS SHALL be latched; changes mid-frame SHALL have no effect.
REQ-021 A latched PRESCALE below 6 SHALL be treated as 6, and a DATA_LEN outside 5..MAX_WIDTH SHALL be treated as MAX_WIDTH.
REQ-022 Edge counter: runs 0..P-1 within each bit, then wraps to 0 and advances the bit counter; it is 0 in the first cycle that IDLE sees the line low.
REQ-023 Sampling: each bit value SHALL be the majority of the line at edge counts P/2-1, P/2 and P/2+1 (P/2 truncated), resolved at edge count P/2+2.
REQ-024 Transitions:
  - IDLE -> START when the line is 0.
  - START: majority 1 (glitch) -> IDLE with no flags; majority 0 -> DATA at the bit wrap.
  - DATA: holds for DATA_LEN bits, LSB first, then -> PARITY if enabled, otherwise -> STOP1.
  - PARITY -> STOP1 at the bit wrap.
  - STOP1 -> STOP2 at the bit wrap if STOP_BITS = 1.
  - Last stop bit -> DONE at edge count P/2+2.
  - DONE -> IDLE after exactly one cycle.
REQ-025 Expected parity SHALL be the XOR of the DATA_LEN data bits for even parity and its inverse for odd parity.
REQ-026 In DONE, PAR_ERR SHALL pulse on a parity mismatch and FRAME_ERR SHALL pulse if any stop bit was sampled 0; both may pulse in the same cycle.
REQ-027 An errored frame SHALL leave P_DATA and DATA_VALID unchanged.
REQ-028 A good frame in DONE with DATA_VALID=0, or with DATA_VALID=1 and DATA_READY=1 in the same cycle, SHALL load P_DATA and set DATA_VALID=1 on the next edge.
REQ-029 A good frame in DONE with DATA_VALID=1 and DATA_READY=0 SHALL be dropped: P_DATA is retained and OVERRUN pulses.
REQ-030 DATA_VALID SHALL clear on the edge after DATA_VALID=1 and DATA_READY=1, unless REQ-028 reloads it in that cycle.
REQ-031 IDLE SHALL accept a new start bit in the cycle after DONE, allowing back-to-back frames.
REQ-032 Frame latency SHALL be first start-low cycle to DATA_VALID = (1+DATA_LEN+PARITY_ENABLE+STOP_BITS)*P + P/2 + 4 CLK cycles.

Reset
REQ-033 RST high SHALL, at any time including mid-frame, force IDLE, clear all counters, set the synchronizer flops to 1, P_DATA=0, and DATA_VALID=PAR_ERR=FRAME_ERR=OVERRUN=BUSY=0.
REQ-034 After RST deasserts, no frame SHALL be reported until a complete new start bit is received.

Verification
REQ-035 P=8, 8N1, byte 0xA5, DATA_READY=1 -> P_DATA=0x0A5 and DATA_VALID high for 1 cycle, no error pulses.
REQ-036 P=16, 7 data bits even parity, two stop bits, 0x35 sent with parity bit 1 -> PAR_ERR pulses once, DATA_VALID stays 0, P_DATA unchanged.
REQ-037 P=8, line low for 3 cycles then high -> return to IDLE, no flags, BUSY deasserts before edge count 8.
REQ-038 P=8, 8N1, 0x11 then 0x22 back-to-back with DATA_READY=0 -> P_DATA=0x011, OVERRUN pulses at the second DONE, DATA_VALID stays 1.
REQ-039 P=8, 9 data bits odd parity, 0x1C3 with the stop bit forced 0 -> FRAME_ERR pulses and PAR_ERR stays 0.
REQ-040 RST asserted during DATA of frame 0x5A, then released and 0x3C sent -> only 0x3C is reported.
